inv_dir_sched: RTL and testbench
================================

Name: inv_dir_sched

Overview:
- Arbiter/sequencer that shares one reciprocal-direction divider unit (computes 1/x, 1/y, 1/z of a ray direction) among NUM_REQ ray requesters.
- Grants requesters round-robin, registers the granted direction, pulses the divider start and waits for its valid.
- Returns the tagged result through a one-entry response register.
- Recovers a hung divider by timeout.
- Sits between the ray-generation front ends and the slab/intersection stage.

Parameters:
- WIDTH, 16, fixed-point width of one component (Q3.12).
- NUM_REQ, 4, number of requesters (>=2).
- ID_W, $clog2(NUM_REQ), requester tag width.
- TIMEOUT, 64, WAIT cycles allowed before the divider is declared hung (>= divider latency + 2).

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_dir  in  NUM_REQ*3*WIDTH  per-requester direction; slice i = {x,y,z}, z in LSBs.
- req_ready  out  NUM_REQ  one-hot accept.
- div_start  out  1  one-cycle start pulse to the divider.
- div_dir  out  3*WIDTH  registered divider operand {x,y,z}.
- div_reset  out  1  active-high, one-cycle divider flush.
- div_valid  in  1  divider result valid.
- div_result  in  3*WIDTH  divider result {1/x,1/y,1/z}.
- resp_valid  out  1  response valid.
- resp_ready  in  1  downstream accept.
- resp_id  out  ID_W  granted requester index.
- resp_dir  out  3*WIDTH  inverse direction.
- resp_err  out  1  1 = timeout, resp_dir forced to 0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_last=NUM_REQ-1 so req 0 has first priority, timer=0; all outputs and data registers 0.
- FSM states: IDLE, LAUNCH, WAIT, FLUSH, RESP.
- IDLE:
  - req_ready is combinational, one-hot, only in IDLE: the first asserted req_valid searching from rr_last+1 upward with wrap.
  - A transfer occurs when req_valid[g] && req_ready[g].
  - On transfer: latch req_dir slice g into div_dir, g into resp_id, rr_last<=g, go to LAUNCH.
  - No req_valid: stay in IDLE, req_ready=0.
- LAUNCH:
  - div_start=1 for exactly this cycle; timer<=0; go to WAIT.
  - div_valid is ignored here (stale result from a previous op).
- WAIT:
  - div_dir is held stable from LAUNCH through WAIT.
  - div_valid=1: capture div_result into resp_dir, resp_err<=0, go to RESP.
  - Otherwise timer increments. If timer==TIMEOUT-1 without div_valid: go to FLUSH.
  - div_valid may be level or pulse; only its first WAIT cycle is captured.
- FLUSH: div_reset=1 for one cycle; resp_dir<=0, resp_err<=1; go to RESP.
- RESP:
  - resp_valid=1, with resp_id, resp_dir and resp_err held stable until resp_ready.
  - On the cycle with resp_valid && resp_ready: go to IDLE. The next grant happens earliest in the following cycle (no same-cycle re-grant).
  - div_valid in RESP is ignored.
- Latency: request accepted at cycle T -> div_start at T+1 -> div_valid at T+1+L -> resp_valid at T+2+L. With resp_ready=1, the next accept is at T+3+L.
- Fairness:
  - Under continuous full load, grant order is 0,1,…,NUM_REQ-1,0,…
  - A requester waits at most NUM_REQ-1 services.
- Requesters must hold req_valid and req_dir stable until accepted; the block does not check this.
- req_valid deasserting before accept is legal; that requester is simply not granted.
- Reset asserted mid-operation:
  - All state clears immediately, including any in-flight op and pending response; no response is emitted.
  - The divider is reset by its own reset, which is outside this block.
- Widths: no arithmetic on data; the timer is $clog2(TIMEOUT) bits and saturates at TIMEOUT-1.

Test Plan:
- Single request: req_valid=4'b0100, req_dir x=y=z=16'h1000 (1.0), divider model L=18 -> req_ready=4'b0100 in the same cycle; div_start 1 cycle later; resp_valid 20 cycles after accept; resp_id=2, resp_dir all 16'h1000, resp_err=0.
- All four requesters valid from reset, each with a distinct dir (x=16'h2000 -> 16'h0800, etc.) -> responses in id order 0,1,2,3, each resp_dir matching its operand; exactly one div_start per ray.
- Fairness: req0 held valid continuously, req3 asserted after the first grant -> grant sequence 0,3,0,0…; req3 is served second.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp_valid, resp_id and resp_dir stable; no req_ready and no div_start during that time; resp_ready=1 -> returns to IDLE, next grant one cycle later.
- Timeout: divider model never asserts div_valid, TIMEOUT=64 -> div_reset pulses 64 cycles after div_start; resp_err=1, resp_dir=0; next request completes normally with resp_err=0.
- Reset mid-WAIT: reset=0 for 2 cycles, 5 cycles after div_start -> busy=0, resp_valid=0 immediately; a late div_valid is ignored; after release, req 0 has first priority.

Source files
------------

// File: rtl/inv_dir_sched.sv
// Round-robin sequencer sharing one reciprocal-direction divider among NUM_REQ ray requesters.
// Latency: accept T -> div_start T+1 -> div_valid T+1+L -> resp_valid T+2+L; timeout flush TIMEOUT cycles after div_start.
// Backpressure: one op in flight; req_ready only in IDLE, response held in RESP until resp_ready.
// Ports: req_valid/req_dir/req_ready (requesters), div_* (divider), resp_* (downstream), busy.
module inv_dir_sched #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*3*WIDTH-1:0] req_dir,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       div_start,
    output logic [3*WIDTH-1:0]         div_dir,
    output logic                       div_reset,
    input  logic                       div_valid,
    input  logic [3*WIDTH-1:0]         div_result,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_W-1:0]            resp_id,
    output logic [3*WIDTH-1:0]         resp_dir,
    output logic                       resp_err,
    output logic                       busy
);

    localparam int DW = 3 * WIDTH;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, FLUSH, RESP} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_last_q, rr_last_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [DW-1:0]   div_dir_q, div_dir_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    logic [DW-1:0]   resp_dir_q, resp_dir_d;
    logic            resp_err_q, resp_err_d;

    logic            found;
    logic [ID_W-1:0] gnt_idx;
    logic [TW-1:0]   timer_inc;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr_last_q) + k) % NUM_REQ]) begin
                found   = 1'b1;
                gnt_idx = ID_W'((int'(rr_last_q) + k) % NUM_REQ);
            end
        end
    end

    // Saturating count; leaving WAIT when the incremented count reaches
    // TIMEOUT-1 puts the flush exactly TIMEOUT cycles after div_start.
    assign timer_inc = (timer_q == TMAX) ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        timer_d    = timer_q;
        div_dir_d  = div_dir_q;
        resp_id_d  = resp_id_q;
        resp_dir_d = resp_dir_q;
        resp_err_d = resp_err_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    div_dir_d = req_dir[gnt_idx*DW +: DW];
                    resp_id_d = gnt_idx;
                    rr_last_d = gnt_idx;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                // div_valid here is a stale result and deliberately ignored.
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (div_valid) begin
                    resp_dir_d = div_result;
                    resp_err_d = 1'b0;
                    state_d    = RESP;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TMAX) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                resp_dir_d = '0;
                resp_err_d = 1'b1;
                state_d    = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_last_q  <= ID_W'(NUM_REQ - 1);
            timer_q    <= '0;
            div_dir_q  <= '0;
            resp_id_q  <= '0;
            resp_dir_q <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            timer_q    <= timer_d;
            div_dir_q  <= div_dir_d;
            resp_id_q  <= resp_id_d;
            resp_dir_q <= resp_dir_d;
            resp_err_q <= resp_err_d;
        end
    end

    always_comb begin
        req_ready = '0;
        req_ready[gnt_idx] = found && (state_q == IDLE);
    end

    assign div_start  = (state_q == LAUNCH);
    assign div_reset  = (state_q == FLUSH);
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign div_dir    = div_dir_q;
    assign resp_id    = resp_id_q;
    assign resp_dir   = resp_dir_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_inv_dir_sched.sv
module tb_inv_dir_sched;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [191:0] req_dir;
    logic [3:0]   req_ready;
    logic         div_start;
    logic [47:0]  div_dir;
    logic         div_reset;
    logic         div_valid;
    logic [47:0]  div_result;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_id;
    logic [47:0]  resp_dir;
    logic         resp_err;
    logic         busy;

    inv_dir_sched #(.WIDTH(16), .NUM_REQ(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_dir(req_dir), .req_ready(req_ready),
        .div_start(div_start), .div_dir(div_dir), .div_reset(div_reset),
        .div_valid(div_valid), .div_result(div_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_dir(resp_dir), .resp_err(resp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Q3.12 reciprocal: 1/x = 2^24 / x, saturated to the positive maximum.
    function automatic logic [15:0] recip(input logic [15:0] x);
        logic [31:0] q;
        if (x == 16'h0) return 16'h7fff;
        q = 32'h0100_0000 / {16'h0, x};
        return (q > 32'h7fff) ? 16'h7fff : q[15:0];
    endfunction

    function automatic logic [47:0] recip3(input logic [47:0] d);
        return {recip(d[47:32]), recip(d[31:16]), recip(d[15:0])};
    endfunction

    function automatic int rr_pick(input int last, input logic [3:0] v);
        for (int k = 1; k <= 4; k++)
            if (v[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    // Divider model: result after lat cycles, or never when hang is set.
    int          lat  = 18;
    bit          hang = 0;
    logic        pend = 1'b0;
    int          cnt  = 0;
    logic [47:0] res_q = '0;
    int          nstart = 0;

    always @(posedge clk) begin
        if (div_start) nstart <= nstart + 1;
        if (div_reset) pend <= 1'b0;
        else if (div_start) begin
            pend  <= !hang;
            cnt   <= lat - 1;
            res_q <= recip3(div_dir);
        end else if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else cnt <= cnt - 1;
        end
    end
    assign div_valid  = pend && (cnt == 0);
    assign div_result = res_q;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_dir(input int i, input logic [47:0] d);
        req_dir[i*48 +: 48] = d;
    endtask

    task automatic do_reset;
        req_valid  = '0;
        resp_ready = 1'b0;
        hang       = 0;
        rst_n      = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic finish_op(input string nm, input int eid, input logic [47:0] edir);
        int n;
        n = 0;
        while (!resp_valid && n < 300) begin
            tick;
            n++;
        end
        chk({nm, "_seen"}, resp_valid, 1);
        chk({nm, "_id"}, resp_id, eid);
        chk({nm, "_dir"}, resp_dir, edir);
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
    endtask

    // Full-load runner: logs grants and responses with resp_ready held high.
    int          gnt_log[8];
    int          rid_log[8];
    logic [47:0] rdir_log[8];

    task automatic run_load(input int ngr, input logic [3:0] drop, input logic [3:0] add);
        int ng, nr, n, g;
        ng = 0; nr = 0; n = 0;
        resp_ready = 1'b1;
        while (nr < ngr && n < 1000) begin
            #1;
            if (|(req_valid & req_ready)) begin
                g = 0;
                for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
                if (ng < 8) gnt_log[ng] = g;
                ng++;
                tick;
                n++;
                if (drop[g]) req_valid[g] = 1'b0;
                if (ng == 1) req_valid = req_valid | add;
            end else begin
                if (resp_valid) begin
                    if (nr < 8) begin
                        rid_log[nr]  = resp_id;
                        rdir_log[nr] = resp_dir;
                    end
                    nr++;
                end
                tick;
                n++;
            end
        end
        req_valid  = '0;
        resp_ready = 1'b0;
        chk("load_done", nr >= ngr, 1);
    endtask

    typedef struct {
        logic [3:0]  vld;
        logic [15:0] comp;
        bit          hng;
        int          l;
        int          exp_id;
        logic [15:0] exp_comp;
        bit          exp_err;
        int          exp_n;
        int          exp_rst;
    } vec_t;

    typedef struct {
        int          id;
        logic [47:0] dir;
    } exp_t;

    vec_t        tbl[8];
    exp_t        exp_q[$];
    exp_t        e_item;
    logic [47:0] rdir[4];
    int          waits[4];
    logic [63:0] tmp;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int n, rst_at, bad, g, e, s0, mdl_last;
        bit gen;
        logic [47:0] edir;

        tbl[0] = '{4'b0100, 16'h1000, 0, 18, 2, 16'h1000, 0, 20, -1};
        tbl[1] = '{4'b1111, 16'h2000, 0,  5, 3, 16'h0800, 0,  7, -1};
        tbl[2] = '{4'b1111, 16'h0800, 0,  1, 0, 16'h2000, 0,  3, -1};
        tbl[3] = '{4'b0011, 16'h4000, 0, 30, 1, 16'h0400, 0, 32, -1};
        tbl[4] = '{4'b0001, 16'h1000, 1, 18, 0, 16'h0000, 1, 66, 65};
        tbl[5] = '{4'b0001, 16'h2000, 0,  3, 0, 16'h0800, 0,  5, -1};
        tbl[6] = '{4'b1001, 16'h1000, 0,  2, 3, 16'h1000, 0,  4, -1};
        tbl[7] = '{4'b1010, 16'h4000, 0, 10, 1, 16'h0400, 0, 12, -1};

        req_valid  = '0;
        req_dir    = '0;
        resp_ready = 1'b0;
        rst_n      = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_div_reset", div_reset, 0);
        chk("rst_div_dir", div_dir, 0);
        chk("rst_resp", {resp_err, resp_id, resp_dir}, 0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        // Table-driven single operations.
        for (int v = 0; v < 8; v++) begin
            lat  = tbl[v].l;
            hang = tbl[v].hng;
            for (int i = 0; i < 4; i++) set_dir(i, {3{tbl[v].comp}});
            req_valid = tbl[v].vld;
            #1;
            chk($sformatf("tbl%0d_ready", v), req_ready, 64'd1 << tbl[v].exp_id);
            tick;
            req_valid = '0;
            chk($sformatf("tbl%0d_start", v), div_start, 1);
            n = 1;
            rst_at = -1;
            while (!resp_valid && n < 300) begin
                tick;
                n++;
                if (div_reset) rst_at = n;
            end
            chk($sformatf("tbl%0d_lat", v), n, tbl[v].exp_n);
            chk($sformatf("tbl%0d_flush", v), rst_at, tbl[v].exp_rst);
            chk($sformatf("tbl%0d_id", v), resp_id, tbl[v].exp_id);
            chk($sformatf("tbl%0d_dir", v), resp_dir, {3{tbl[v].exp_comp}});
            chk($sformatf("tbl%0d_err", v), resp_err, tbl[v].exp_err);
            resp_ready = 1'b1;
            tick;
            resp_ready = 1'b0;
        end
        hang = 0;

        // Backpressure: hold the response 10 cycles with another request pending.
        lat = 6;
        set_dir(0, {3{16'h1000}});
        set_dir(2, {3{16'h2000}});
        req_valid = 4'b0001;
        tick;
        req_valid = 4'b0100;
        n = 0;
        while (!resp_valid && n < 300) begin
            tick;
            n++;
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (!resp_valid || resp_id != 2'd0 || resp_dir != {3{16'h1000}} ||
                req_ready != 4'b0 || div_start) bad++;
            tick;
        end
        chk("bp_stable", bad, 0);
        resp_ready = 1'b1;
        #1;
        chk("bp_no_regrant", req_ready, 0);
        tick;
        resp_ready = 1'b0;
        chk("bp_next_grant", req_ready, 4'b0100);
        tick;
        req_valid = '0;
        finish_op("bp_op2", 2, {3{16'h0800}});

        // Reset during WAIT: previous grant was 2, now grant 0, then reset.
        lat = 18;
        set_dir(0, {3{16'h4000}});
        set_dir(3, {3{16'h2000}});
        req_valid = 4'b0001;
        #1;
        tick;
        req_valid = '0;
        chk("rw_launch", div_start, 1);
        for (int k = 0; k < 5; k++) tick;
        rst_n = 1'b0;
        #1;
        chk("rw_busy", busy, 0);
        chk("rw_resp_valid", resp_valid, 0);
        tick;
        tick;
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (busy || resp_valid) bad++;
        end
        chk("rw_ignore_late", bad, 0);
        req_valid = 4'b1001;
        #1;
        chk("rw_prio", req_ready, 4'b0001);
        tick;
        req_valid = '0;
        finish_op("rw_op", 0, {3{16'h0400}});

        // All four requesters from reset, distinct operands.
        do_reset();
        lat = 4;
        set_dir(0, {16'h2000, 16'h1000, 16'h0800});
        set_dir(1, {16'h4000, 16'h2000, 16'h1000});
        set_dir(2, {16'h0800, 16'h4000, 16'h2000});
        set_dir(3, {16'h1000, 16'h0800, 16'h4000});
        s0 = nstart;
        req_valid = 4'b1111;
        run_load(4, 4'b1111, 4'b0000);
        chk("all4_starts", nstart - s0, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("all4_gnt%0d", i), gnt_log[i], i);
            chk($sformatf("all4_id%0d", i), rid_log[i], i);
            chk($sformatf("all4_dir%0d", i), rdir_log[i], recip3(req_dir[i*48 +: 48]));
        end

        // Fairness: req0 always valid, req3 joins after the first grant.
        do_reset();
        req_valid = 4'b0001;
        run_load(4, 4'b1000, 4'b1000);
        chk("fair_g0", gnt_log[0], 0);
        chk("fair_g1", gnt_log[1], 3);
        chk("fair_g2", gnt_log[2], 0);
        chk("fair_g3", gnt_log[3], 0);

        // Randomized traffic against a transaction-level model.
        do_reset();
        mdl_last = 3;
        for (int i = 0; i < 4; i++) waits[i] = 0;
        n = 0;
        gen = 1;
        while (n < 5000 && (gen || req_valid != 4'b0 || exp_q.size() != 0)) begin
            gen = (n < 2500);
            resp_ready = 1'($urandom_range(0, 1));
            lat = $urandom_range(1, 20);
            if (gen) begin
                for (int i = 0; i < 4; i++) begin
                    if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                        tmp = {$urandom(), $urandom()};
                        rdir[i] = tmp[47:0];
                        set_dir(i, rdir[i]);
                        req_valid[i] = 1'b1;
                    end
                end
            end
            #1;
            g = -1;
            if (req_ready != 4'b0) begin
                e = rr_pick(mdl_last, req_valid);
                chk("rand_grant", req_ready, (e < 0) ? 64'd0 : (64'd1 << e));
                chk("rand_one_op", exp_q.size(), 0);
                if (e >= 0) begin
                    chk("rand_fair", waits[e] <= 3, 1);
                    for (int j = 0; j < 4; j++) if (j != e && req_valid[j]) waits[j]++;
                    waits[e] = 0;
                    e_item.id  = e;
                    e_item.dir = recip3(rdir[e]);
                    exp_q.push_back(e_item);
                    mdl_last = e;
                    g = e;
                end
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) chk("rand_spurious", 1, 0);
                else begin
                    e_item = exp_q.pop_front();
                    chk("rand_id", resp_id, e_item.id);
                    chk("rand_dir", resp_dir, e_item.dir);
                    chk("rand_err", resp_err, 0);
                end
            end
            tick;
            n++;
            if (g >= 0) req_valid[g] = 1'b0;
        end
        chk("rand_drain", {req_valid, 28'(exp_q.size())}, 0);
        req_valid  = '0;
        resp_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
